// File: rtl/iob_cache_axi_mem_responder_pkg.sv
// Shared AXI response codes, FSM state encodings and arbiter port indices
// for the AXI-to-native-memory responder.
package iob_cache_axi_mem_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT,
        R_DATA
    } r_state_t;

    // Requester slots on the memory-port arbiter.
    localparam int unsigned GNT_W = 0;
    localparam int unsigned GNT_R = 1;

endpackage

// File: rtl/iob_cache_axi_mem_responder_arb2.sv
// Two-requester round-robin arbiter; the last-grant bit only moves when
// both sides request in the same cycle.
module iob_cache_mem_arb2
    import iob_cache_axi_mem_responder_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // 1: requester GNT_R won the last contended cycle.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        case (req_i)
            2'b01: gnt_o[GNT_W] = 1'b1;
            2'b10: gnt_o[GNT_R] = 1'b1;
            2'b11: begin
                if (last_q) begin
                    gnt_o[GNT_W] = 1'b1;
                    last_d       = 1'b0;
                end else begin
                    gnt_o[GNT_R] = 1'b1;
                    last_d       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/iob_cache_axi_mem_responder.sv
// AXI4 responder terminating one read and one write INCR burst at a time
// onto a single-port synchronous memory shared through a round-robin arbiter.
module iob_cache_axi_mem_responder
    import iob_cache_axi_mem_responder_pkg::*;
#(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int NBYTES_W   = $clog2(AXI_DATA_W / 8),
    parameter int MEM_ADDR_W = AXI_ADDR_W - NBYTES_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic [1:0]              axi_awlock_i,
    input  logic [3:0]              axi_awcache_i,
    input  logic [2:0]              axi_awprot_i,
    input  logic [3:0]              axi_awqos_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,

    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,

    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,

    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic [1:0]              axi_arlock_i,
    input  logic [3:0]              axi_arcache_i,
    input  logic [2:0]              axi_arprot_i,
    input  logic [3:0]              axi_arqos_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,

    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,

    output logic                    mem_en_o,
    output logic [AXI_DATA_W/8-1:0] mem_we_o,
    output logic [MEM_ADDR_W-1:0]   mem_addr_o,
    output logic [AXI_DATA_W-1:0]   mem_wdata_o,
    input  logic [AXI_DATA_W-1:0]   mem_rdata_i
);

    w_state_t              w_state_q, w_state_d;
    logic [AXI_ID_W-1:0]   w_id_q,    w_id_d;
    logic [MEM_ADDR_W-1:0] w_addr_q,  w_addr_d;
    logic [AXI_LEN_W-1:0]  w_len_q,   w_len_d;
    logic [AXI_LEN_W-1:0]  w_cnt_q,   w_cnt_d;
    logic                  w_err_q,   w_err_d;

    r_state_t              r_state_q, r_state_d;
    logic [AXI_ID_W-1:0]   r_id_q,    r_id_d;
    logic [MEM_ADDR_W-1:0] r_addr_q,  r_addr_d;
    logic [AXI_LEN_W-1:0]  r_len_q,   r_len_d;
    logic [AXI_LEN_W-1:0]  r_cnt_q,   r_cnt_d;
    logic [AXI_DATA_W-1:0] r_data_q,  r_data_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       w_last;
    logic       r_last;

    logic unused_inputs;
    assign unused_inputs = ^{axi_awsize_i, axi_awburst_i, axi_awlock_i, axi_awcache_i,
                             axi_awprot_i, axi_awqos_i, axi_awaddr_i[NBYTES_W-1:0],
                             axi_arsize_i, axi_arburst_i, axi_arlock_i, axi_arcache_i,
                             axi_arprot_i, axi_arqos_i, axi_araddr_i[NBYTES_W-1:0]};

    assign w_last = (w_cnt_q == w_len_q);
    assign r_last = (r_cnt_q == r_len_q);

    always_comb begin
        req        = '0;
        req[GNT_W] = (w_state_q == W_DATA) && axi_wvalid_i;
        req[GNT_R] = (r_state_q == R_REQ);
    end

    iob_cache_mem_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req),
        .gnt_o (gnt)
    );

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (axi_awvalid_i) begin
                    w_id_d    = axi_awid_i;
                    w_addr_d  = axi_awaddr_i[AXI_ADDR_W-1:NBYTES_W];
                    w_len_d   = axi_awlen_i;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // A grant implies wvalid, so it doubles as the w handshake.
                if (gnt[GNT_W]) begin
                    w_addr_d = w_addr_q + MEM_ADDR_W'(1);
                    w_cnt_d  = w_cnt_q + AXI_LEN_W'(1);
                    if (axi_wlast_i != w_last) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_data_d  = r_data_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi_arvalid_i) begin
                    r_id_d    = axi_arid_i;
                    r_addr_d  = axi_araddr_i[AXI_ADDR_W-1:NBYTES_W];
                    r_len_d   = axi_arlen_i;
                    r_cnt_d   = '0;
                    r_state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (gnt[GNT_R]) begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                r_data_d  = mem_rdata_i;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi_rready_i) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d  = r_addr_q + MEM_ADDR_W'(1);
                        r_cnt_d   = r_cnt_q + AXI_LEN_W'(1);
                        r_state_d = R_REQ;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Outputs are forced low for the whole reset window, not only after the first edge.
    always_comb begin
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bid_o     = '0;
        axi_bresp_o   = RESP_OKAY;
        axi_bvalid_o  = 1'b0;
        axi_arready_o = 1'b0;
        axi_rid_o     = '0;
        axi_rdata_o   = '0;
        axi_rresp_o   = RESP_OKAY;
        axi_rlast_o   = 1'b0;
        axi_rvalid_o  = 1'b0;
        mem_en_o      = 1'b0;
        mem_we_o      = '0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        if (!rst_i) begin
            axi_awready_o = (w_state_q == W_IDLE);
            axi_wready_o  = gnt[GNT_W];
            axi_bvalid_o  = (w_state_q == W_RESP);
            axi_bid_o     = w_id_q;
            axi_bresp_o   = w_err_q ? RESP_SLVERR : RESP_OKAY;
            axi_arready_o = (r_state_q == R_IDLE);
            axi_rvalid_o  = (r_state_q == R_DATA);
            axi_rid_o     = r_id_q;
            axi_rdata_o   = r_data_q;
            axi_rlast_o   = (r_state_q == R_DATA) && r_last;
            if (gnt[GNT_W]) begin
                mem_en_o    = 1'b1;
                mem_we_o    = axi_wstrb_i;
                mem_addr_o  = w_addr_q;
                mem_wdata_o = axi_wdata_i;
            end else if (gnt[GNT_R]) begin
                mem_en_o    = 1'b1;
                mem_addr_o  = r_addr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_data_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_data_q  <= r_data_d;
        end
    end

endmodule

// File: tb/tb_iob_cache_axi_mem_responder.sv
// Directed bench for iob_cache_axi_mem_responder with a behavioural
// 1-cycle-latency memory attached to the native port.
module tb_iob_cache_axi_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        awid = 1'b0;
    logic [23:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        arid = 1'b0;
    logic [23:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic        rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [2:0] tie3 = '0;
    logic [1:0] tie2 = '0;
    logic [3:0] tie4 = '0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] mem [0:4095];
    logic [22:0] glog [$];
    logic        log_on = 1'b0;

    iob_cache_axi_mem_responder #(
        .AXI_ID_W   (1),
        .AXI_ADDR_W (24),
        .AXI_DATA_W (32),
        .AXI_LEN_W  (8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
        .axi_awsize_i(tie3), .axi_awburst_i(tie2), .axi_awlock_i(tie2),
        .axi_awcache_i(tie4), .axi_awprot_i(tie3), .axi_awqos_i(tie4),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
        .axi_arsize_i(tie3), .axi_arburst_i(tie2), .axi_arlock_i(tie2),
        .axi_arcache_i(tie4), .axi_arprot_i(tie3), .axi_arqos_i(tie4),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
        .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr[11:0]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[11:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (log_on && mem_en) glog.push_back({|mem_we, mem_addr});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic id, input logic [23:0] addr, input logic [7:0] len);
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) step();
        total_cnt++;
        if (awready !== 1'b1) $display("FAIL aw_accept got awready=%b want 1", awready);
        else pass_cnt++;
        step();
        awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic id, input logic [23:0] addr, input logic [7:0] len);
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        for (int n = 0; n < 50 && !arready; n++) step();
        total_cnt++;
        if (arready !== 1'b1) $display("FAIL ar_accept got arready=%b want 1", arready);
        else pass_cnt++;
        step();
        arvalid = 1'b0;
    endtask

    task automatic send_wbeats(input int n, input logic [31:0] base, input int early);
        for (int i = 0; i < n; i++) begin
            wdata = base + i; wstrb = 4'hF; wvalid = 1'b1;
            wlast = (early >= 0) ? (i == early) : (i == n - 1);
            #1;
            for (int k = 0; k < 50 && !wready; k++) step();
            total_cnt++;
            if (wready !== 1'b1) $display("FAIL w_beat%0d got wready=%b want 1", i, wready);
            else pass_cnt++;
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b(input logic id, input logic [1:0] resp);
        bready = 1'b1;
        for (int n = 0; n < 50 && !bvalid; n++) step();
        total_cnt++;
        if (bvalid !== 1'b1 || bresp !== resp || bid !== id)
            $display("FAIL bresp got valid=%b resp=%b id=%b want valid=1 resp=%b id=%b",
                     bvalid, bresp, bid, resp, id);
        else pass_cnt++;
        step();
        bready = 1'b0;
    endtask

    task automatic recv_beats(input int start, input int count, input int len,
                              input logic [31:0] base, input logic id, input int stall);
        logic [31:0] held;
        rready = 1'b1;
        for (int b = start; b < start + count; b++) begin
            for (int n = 0; n < 50 && !rvalid; n++) step();
            total_cnt++;
            if (rvalid !== 1'b1 || rdata !== base + b || rlast !== (b == len) ||
                rid !== id || rresp !== 2'b00)
                $display("FAIL r_beat%0d got v=%b d=%h last=%b id=%b resp=%b want v=1 d=%h last=%b id=%b resp=00",
                         b, rvalid, rdata, rlast, rid, rresp, base + b, (b == len), id);
            else pass_cnt++;
            if (b == stall) begin
                rready = 1'b0;
                held = rdata;
                for (int k = 0; k < 5; k++) begin
                    step();
                    total_cnt++;
                    if (rvalid !== 1'b1 || rdata !== held || mem_en !== 1'b0)
                        $display("FAIL stall%0d got v=%b d=%h mem_en=%b want v=1 d=%h mem_en=0",
                                 k, rvalid, rdata, mem_en, held);
                    else pass_cnt++;
                end
                rready = 1'b1;
            end
            step();
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 1'b1; arvalid = 1'b1;
        step(); step();
        total_cnt++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, mem_en, mem_we} !== '0)
            $display("FAIL reset_outputs got aw=%b ar=%b w=%b b=%b r=%b en=%b we=%h want all 0",
                     awready, arready, wready, bvalid, rvalid, mem_en, mem_we);
        else pass_cnt++;
        awvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b0;
        step();
        total_cnt++;
        if (awready !== 1'b1 || arready !== 1'b1)
            $display("FAIL post_reset_ready got aw=%b ar=%b want 1 1", awready, arready);
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        do_aw(1'b1, 24'h000100, 8'd0);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        #1;
        total_cnt++;
        if (wready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'hF ||
            mem_addr !== 22'h40 || mem_wdata !== 32'hDEADBEEF)
            $display("FAIL single_write_port got rdy=%b en=%b we=%h a=%h d=%h want 1 1 f 40 deadbeef",
                     wready, mem_en, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        step();
        wvalid = 1'b0; wlast = 1'b0;
        total_cnt++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 1'b1)
            $display("FAIL single_write_b got v=%b resp=%b id=%b want 1 00 1", bvalid, bresp, bid);
        else pass_cnt++;
        bready = 1'b1;
        step();
        bready = 1'b0;
        total_cnt++;
        if (bvalid !== 1'b0 || awready !== 1'b1)
            $display("FAIL single_write_bdone got bvalid=%b awready=%b want 0 1", bvalid, awready);
        else pass_cnt++;
        total_cnt++;
        if (mem[12'h040] !== 32'hDEADBEEF)
            $display("FAIL single_write_mem got %h want deadbeef", mem[12'h040]);
        else pass_cnt++;
    endtask

    task automatic test_read_burst();
        for (int i = 0; i < 8; i++) mem[12'h080 + i] = 32'h80 + i;
        do_ar(1'b1, 24'h000200, 8'd7);
        total_cnt++;
        if (rvalid !== 1'b0) $display("FAIL read_lat_t1 got rvalid=%b want 0", rvalid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rvalid !== 1'b0) $display("FAIL read_lat_t2 got rvalid=%b want 0", rvalid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rvalid !== 1'b1) $display("FAIL read_lat_t3 got rvalid=%b want 1", rvalid);
        else pass_cnt++;
        recv_beats(0, 8, 7, 32'h80, 1'b1, -1);
    endtask

    task automatic test_backpressure();
        do_ar(1'b0, 24'h000200, 8'd7);
        recv_beats(0, 8, 7, 32'h80, 1'b0, 2);
    endtask

    task automatic test_contention();
        logic ok;
        rst = 1'b1; step(); rst = 1'b0; step();
        for (int i = 0; i < 4; i++) mem[12'h200 + i] = 32'hA000 + i;
        glog.delete();
        awid = 1'b0; awaddr = 24'h000400; awlen = 8'd3;
        arid = 1'b1; araddr = 24'h000800; arlen = 8'd3;
        awvalid = 1'b1; arvalid = 1'b1; log_on = 1'b1;
        total_cnt++;
        if (awready !== 1'b1 || arready !== 1'b1)
            $display("FAIL contention_accept got aw=%b ar=%b want 1 1", awready, arready);
        else pass_cnt++;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        fork
            begin
                send_wbeats(4, 32'hC000, -1);
                wait_b(1'b0, 2'b00);
            end
            recv_beats(0, 4, 3, 32'hA000, 1'b1, -1);
        join
        log_on = 1'b0;
        total_cnt++;
        if (glog.size() < 2 || glog[0] !== {1'b1, 22'h100} || glog[1] !== {1'b0, 22'h200})
            $display("FAIL contention_order got n=%0d g0=%h g1=%h want g0=%h g1=%h",
                     glog.size(), (glog.size() > 0) ? glog[0] : 23'h0,
                     (glog.size() > 1) ? glog[1] : 23'h0, {1'b1, 22'h100}, {1'b0, 22'h200});
        else pass_cnt++;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (mem[12'h100 + i] !== 32'hC000 + i) ok = 1'b0;
        total_cnt++;
        if (ok !== 1'b1)
            $display("FAIL contention_wmem got %h %h %h %h want c000..c003",
                     mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]);
        else pass_cnt++;
    endtask

    task automatic test_protocol_error();
        logic ok;
        do_aw(1'b1, 24'h001000, 8'd3);
        send_wbeats(4, 32'hE000, 1);
        wait_b(1'b1, 2'b10);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (mem[12'h400 + i] !== 32'hE000 + i) ok = 1'b0;
        total_cnt++;
        if (ok !== 1'b1)
            $display("FAIL err_burst_mem got %h %h %h %h want e000..e003",
                     mem[12'h400], mem[12'h401], mem[12'h402], mem[12'h403]);
        else pass_cnt++;
        do_aw(1'b0, 24'h001100, 8'd1);
        send_wbeats(2, 32'hF000, -1);
        wait_b(1'b0, 2'b00);
        total_cnt++;
        if (mem[12'h441] !== 32'hF001)
            $display("FAIL clean_burst_mem got %h want 0000f001", mem[12'h441]);
        else pass_cnt++;
    endtask

    task automatic test_reset_midburst();
        do_ar(1'b0, 24'h000200, 8'd7);
        recv_beats(0, 2, 7, 32'h80, 1'b0, -1);
        for (int n = 0; n < 50 && !rvalid; n++) step();
        total_cnt++;
        if (rvalid !== 1'b1 || rdata !== 32'h82)
            $display("FAIL midburst_beat3 got v=%b d=%h want 1 00000082", rvalid, rdata);
        else pass_cnt++;
        rst = 1'b1;
        step();
        total_cnt++;
        if (rvalid !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL midburst_reset got rvalid=%b mem_en=%b want 0 0", rvalid, mem_en);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (arready !== 1'b1 || rvalid !== 1'b0)
            $display("FAIL midburst_release got arready=%b rvalid=%b want 1 0", arready, rvalid);
        else pass_cnt++;
        do_ar(1'b1, 24'h000204, 8'd1);
        recv_beats(0, 2, 1, 32'h81, 1'b1, -1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        test_reset();
        test_single_write();
        test_read_burst();
        test_backpressure();
        test_contention();
        test_protocol_error();
        test_reset_midburst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
